// File: rtl/rcservo_pkg.sv
// Shared constants for the multi-channel RC servo / PWM generator:
// register map addresses and CTRL bit positions.
package rcservo_pkg;
  localparam int unsigned ADDR_DIV    = 32'd0;
  localparam int unsigned ADDR_PERIOD = 32'd1;
  localparam int unsigned ADDR_CTRL   = 32'd2;
  localparam int unsigned ADDR_CHEN   = 32'd3;
  localparam int unsigned ADDR_POL    = 32'd4;
  localparam int unsigned ADDR_STAT   = 32'd5;
  localparam int unsigned ADDR_WIDTH0 = 32'd6;

  localparam int unsigned CTRL_GEN   = 32'd0;
  localparam int unsigned CTRL_DEFER = 32'd1;
endpackage

// File: rtl/rcservo_multi_if.sv
// Local 16-bit register bus between a bus master and the servo block.
interface rcservo_multi_if #(
  parameter int AW = 5
) ();
  logic [AW-1:0] Addr;
  logic [15:0]   DataRd;
  logic [15:0]   DataWr;
  logic          En;
  logic          Rd;
  logic          Wr;

  modport master (output Addr, output DataWr, output En, output Rd, output Wr, input DataRd);
  modport slave  (input Addr, input DataWr, input En, input Rd, input Wr, output DataRd);
endinterface

// File: rtl/rcservo_channel.sv
// One PWM channel: shadowed pulse width, compare against the shared period
// counter, and the registered output pin.
module rcservo_channel #(
  parameter int CW = 14
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [CW-1:0] per_cnt_i,
  input  logic          pstart_i,
  input  logic          defer_i,
  input  logic [CW-1:0] width_i,
  input  logic          en_i,
  input  logic          pol_i,
  output logic          p_o
);
  logic [CW-1:0] shadow_q, shadow_d;
  logic          p_q, p_d;
  logic          act_s;

  // Shadow follows the pending width immediately, or only at period start when deferred.
  always_comb begin
    shadow_d = shadow_q;
    if (!defer_i || pstart_i) begin
      shadow_d = width_i;
    end else begin
      shadow_d = shadow_q;
    end
    act_s = en_i & (shadow_q != '0) & (per_cnt_i < shadow_q);
    p_d   = act_s ^ pol_i;
  end

  // Shadow and output flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_q <= '0;
      p_q      <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      p_q      <= p_d;
    end
  end

  assign p_o = p_q;
endmodule

// File: rtl/rcservo_multi.sv
// Multi-channel RC servo / PWM generator: register file, shared prescaler
// and period counter, and one rcservo_channel per output.
module rcservo_multi
  import rcservo_pkg::*;
#(
  parameter int NCH = 12,
  parameter int CW  = 14,
  parameter int DW  = 9,
  parameter int AW  = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  rcservo_multi_if.slave bus,
  output logic [NCH-1:0] P
);
  logic [DW-1:0]  div_q;
  logic [CW-1:0]  period_q;
  logic           gen_q, defer_q;
  logic [NCH-1:0] chen_q, pol_q;
  logic [CW-1:0]  width_q [NCH];

  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic [CW-1:0]  per_cnt_q, per_cnt_d;
  logic [15:0]    stat_q, stat_d;
  logic           tick_s, pstart_s, wr_s;
  logic [15:0]    rd_data_s, rd_width_s;
  logic           unused_s;

  assign wr_s     = bus.En & bus.Wr;
  assign unused_s = ^{bus.Rd, bus.DataWr};

  // Register writes; STAT and unmapped addresses are not writable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q    <= '0;
      period_q <= '0;
      gen_q    <= 1'b0;
      defer_q  <= 1'b0;
      chen_q   <= '0;
      pol_q    <= '0;
      for (int i = 0; i < NCH; i++) width_q[i] <= '0;
    end else if (wr_s) begin
      case (bus.Addr)
        AW'(ADDR_DIV):    div_q    <= bus.DataWr[DW-1:0];
        AW'(ADDR_PERIOD): period_q <= bus.DataWr[CW-1:0];
        AW'(ADDR_CTRL): begin
          gen_q   <= bus.DataWr[CTRL_GEN];
          defer_q <= bus.DataWr[CTRL_DEFER];
        end
        AW'(ADDR_CHEN):   chen_q   <= bus.DataWr[NCH-1:0];
        AW'(ADDR_POL):    pol_q    <= bus.DataWr[NCH-1:0];
        default:          ;
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (bus.Addr == AW'(ADDR_WIDTH0 + i)) width_q[i] <= bus.DataWr[CW-1:0];
      end
    end
  end

  // Prescaler and period counter; >= compares let a shrunken terminal wrap at once.
  always_comb begin
    tick_s    = (div_cnt_q >= div_q);
    pstart_s  = 1'b0;
    div_cnt_d = div_cnt_q + DW'(1);
    per_cnt_d = per_cnt_q;
    stat_d    = stat_q;
    if (tick_s) begin
      div_cnt_d = '0;
      if (per_cnt_q >= period_q) begin
        per_cnt_d = '0;
        pstart_s  = 1'b1;
        stat_d    = stat_q + 16'd1;
      end else begin
        per_cnt_d = per_cnt_q + CW'(1);
      end
    end else begin
      per_cnt_d = per_cnt_q;
    end
  end

  // Counter state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt_q <= '0;
      per_cnt_q <= '0;
      stat_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      per_cnt_q <= per_cnt_d;
      stat_q    <= stat_d;
    end
  end

  // Read mux; width reads return the pending value, not the shadow.
  always_comb begin
    rd_width_s = 16'h0000;
    for (int i = 0; i < NCH; i++) begin
      rd_width_s = rd_width_s |
                   ((bus.Addr == AW'(ADDR_WIDTH0 + i)) ? 16'(width_q[i]) : 16'h0000);
    end
    case (bus.Addr)
      AW'(ADDR_DIV):    rd_data_s = 16'(div_q);
      AW'(ADDR_PERIOD): rd_data_s = 16'(period_q);
      AW'(ADDR_CTRL):   rd_data_s = {14'h0000, defer_q, gen_q};
      AW'(ADDR_CHEN):   rd_data_s = 16'(chen_q);
      AW'(ADDR_POL):    rd_data_s = 16'(pol_q);
      AW'(ADDR_STAT):   rd_data_s = stat_q;
      default:          rd_data_s = rd_width_s;
    endcase
  end

  assign bus.DataRd = rd_data_s;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rcservo_channel #(.CW(CW)) u_ch (
      .Clk       (Clk),
      .Reset     (Reset),
      .per_cnt_i (per_cnt_q),
      .pstart_i  (pstart_s),
      .defer_i   (defer_q),
      .width_i   (width_q[g]),
      .en_i      (gen_q & chen_q[g]),
      .pol_i     (pol_q[g]),
      .p_o       (P[g])
    );
  end
endmodule
